// File: rtl/z80_ir_refresh_pkg.sv
// Shared definitions for the Z80 I/R register and DRAM refresh sequencer.
package z80_ir_refresh_pkg;

    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_T3   = 2'd1,
        RF_T4   = 2'd2
    } rf_state_e;

    localparam logic [7:0] R_INC_MASK = 8'h7F;
    localparam logic [7:0] I_RST_VAL  = 8'h00;
    localparam logic [7:0] R_RST_VAL  = 8'h00;

    // Only the low 7 bits of R count; bit 7 is whatever was last loaded.
    function automatic logic [7:0] r_next(input logic [7:0] r);
        logic [7:0] sum;
        sum    = r + 8'd1;
        r_next = (r & ~R_INC_MASK) | (sum & R_INC_MASK);
    endfunction

endpackage

// File: rtl/z80_ir_refresh_r_counter.sv
// Z80 R register: full 8-bit load, 7-bit wrapping increment, load beats increment.
module z80_r_counter
    import z80_ir_refresh_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       r_we,
    input  logic       r_inc,
    input  logic [7:0] wdata,
    output logic [7:0] reg_r
);

    logic [7:0] r_d, r_q;

    always_comb begin
        r_d = r_q;
        if (r_we)
            r_d = wdata;
        else if (r_inc)
            r_d = r_next(r_q);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_q <= R_RST_VAL;
        else
            r_q <= r_d;
    end

    assign reg_r = r_q;

endmodule

// File: rtl/z80_ir_refresh.sv
// Z80 I/R registers and the T3/T4 refresh half of every M1 cycle.
module z80_ir_refresh
    import z80_ir_refresh_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_start,
    input  logic        i_we,
    input  logic        r_we,
    input  logic [7:0]  wdata,
    output logic [7:0]  reg_i,
    output logic [7:0]  reg_r,
    output logic        rfsh,
    output logic        rfsh_mreq,
    output logic [15:0] rfsh_addr,
    output logic        busy,
    output logic        overrun
);

    rf_state_e   state_d, state_q;
    logic [7:0]  i_d, i_q;
    logic [15:0] addr_d, addr_q;
    logic        overrun_d, overrun_q;
    logic        start_ok;

    // A start on the T4->IDLE edge sees state_q==RF_T4, so it is dropped too.
    assign start_ok = m1_start && (state_q == RF_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RF_IDLE: if (m1_start) state_d = RF_T3;
            RF_T3:   state_d = RF_T4;
            RF_T4:   state_d = RF_IDLE;
            default: state_d = RF_IDLE;
        endcase
    end

    always_comb begin
        i_d       = i_we ? wdata : i_q;
        addr_d    = start_ok ? {i_q, reg_r} : addr_q;
        overrun_d = m1_start && (state_q != RF_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_IDLE;
            i_q       <= I_RST_VAL;
            addr_q    <= 16'h0000;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
        end
    end

    z80_r_counter u_r_counter (
        .clk   (clk),
        .reset (reset),
        .r_we  (r_we),
        .r_inc (state_q == RF_T4),
        .wdata (wdata),
        .reg_r (reg_r)
    );

    assign reg_i     = i_q;
    assign rfsh      = (state_q == RF_T3) || (state_q == RF_T4);
    assign rfsh_mreq = (state_q == RF_T3);
    assign rfsh_addr = addr_q;
    assign busy      = (state_q != RF_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_z80_ir_refresh.sv
// Directed bench for z80_ir_refresh; expectations queued per cycle and checked after the edge.
module tb_z80_ir_refresh;

    logic        clk = 1'b0;
    logic        reset, m1_start, i_we, r_we;
    logic [7:0]  wdata;
    logic [7:0]  reg_i, reg_r;
    logic        rfsh, rfsh_mreq, busy, overrun;
    logic [15:0] rfsh_addr;

    localparam int F_RFSH = 0, F_MREQ = 1, F_ADDR = 2, F_I = 3, F_R = 4, F_BUSY = 5, F_OVR = 6;

    typedef struct {
        string       tag;
        int          fld;
        logic [15:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    z80_ir_refresh dut (
        .clk       (clk),
        .reset     (reset),
        .m1_start  (m1_start),
        .i_we      (i_we),
        .r_we      (r_we),
        .wdata     (wdata),
        .reg_i     (reg_i),
        .reg_r     (reg_r),
        .rfsh      (rfsh),
        .rfsh_mreq (rfsh_mreq),
        .rfsh_addr (rfsh_addr),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obs(input int f);
        case (f)
            F_RFSH:  obs = {15'd0, rfsh};
            F_MREQ:  obs = {15'd0, rfsh_mreq};
            F_ADDR:  obs = rfsh_addr;
            F_I:     obs = {8'd0, reg_i};
            F_R:     obs = {8'd0, reg_r};
            F_BUSY:  obs = {15'd0, busy};
            default: obs = {15'd0, overrun};
        endcase
    endfunction

    task automatic ex(input string tag, input int f, input logic [15:0] v);
        exp_t e;
        e.tag = tag; e.fld = f; e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic ex_reset(input string tag);
        ex({tag, "_rfsh"}, F_RFSH, 16'h0);
        ex({tag, "_mreq"}, F_MREQ, 16'h0);
        ex({tag, "_addr"}, F_ADDR, 16'h0000);
        ex({tag, "_i"},    F_I,    16'h0000);
        ex({tag, "_r"},    F_R,    16'h0000);
        ex({tag, "_busy"}, F_BUSY, 16'h0);
        ex({tag, "_ovr"},  F_OVR,  16'h0);
    endtask

    // Clock one edge, then compare everything queued for the post-edge state.
    task automatic tick();
        exp_t        e;
        logic [15:0] o;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs(e.fld);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        m1_start = 1'b0; i_we = 1'b0; r_we = 1'b0; wdata = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        ex_reset("rst");
        tick();
        reset = 1'b0;

        // Basic M1 from I=0,R=0
        m1_start = 1'b1;
        ex("m1_t3_rfsh", F_RFSH, 16'h1); ex("m1_t3_mreq", F_MREQ, 16'h1);
        ex("m1_t3_addr", F_ADDR, 16'h0000); ex("m1_t3_busy", F_BUSY, 16'h1);
        tick();
        m1_start = 1'b0;
        ex("m1_t4_rfsh", F_RFSH, 16'h1); ex("m1_t4_mreq", F_MREQ, 16'h0);
        ex("m1_t4_r", F_R, 16'h0000);
        tick();
        ex("m1_end_rfsh", F_RFSH, 16'h0); ex("m1_end_busy", F_BUSY, 16'h0);
        ex("m1_end_r", F_R, 16'h0001);
        tick();

        // Wrap 0x7F -> 0x00
        r_we = 1'b1; wdata = 8'h7F;
        ex("ld_r_7f", F_R, 16'h007F);
        tick();
        idle_inputs(); m1_start = 1'b1;
        tick();
        m1_start = 1'b0;
        tick();
        ex("wrap_7f", F_R, 16'h0000);
        tick();

        // Wrap 0xFF -> 0x80
        r_we = 1'b1; wdata = 8'hFF;
        tick();
        idle_inputs(); m1_start = 1'b1;
        ex("addr_ff", F_ADDR, 16'h00FF);
        tick();
        m1_start = 1'b0;
        tick();
        ex("wrap_ff", F_R, 16'h0080);
        tick();

        // I write during T3 does not disturb the latched address
        i_we = 1'b1; wdata = 8'h12;
        tick();
        idle_inputs(); r_we = 1'b1; wdata = 8'h05;
        ex("ld_i_12", F_I, 16'h0012); ex("ld_r_05", F_R, 16'h0005);
        tick();
        idle_inputs(); m1_start = 1'b1;
        ex("addr_1205_t3", F_ADDR, 16'h1205);
        tick();
        idle_inputs(); i_we = 1'b1; wdata = 8'h3C;
        ex("addr_1205_t4", F_ADDR, 16'h1205); ex("i_3c", F_I, 16'h003C);
        ex("t4_after_iwe_rfsh", F_RFSH, 16'h1);
        tick();
        idle_inputs();
        ex("r_06", F_R, 16'h0006); ex("addr_hold", F_ADDR, 16'h1205);
        tick();
        m1_start = 1'b1;
        ex("addr_3c06", F_ADDR, 16'h3C06);
        tick();
        m1_start = 1'b0;
        tick();
        ex("r_07", F_R, 16'h0007);
        tick();

        // Write on the increment edge wins
        r_we = 1'b1; wdata = 8'h10;
        tick();
        idle_inputs(); m1_start = 1'b1;
        tick();
        m1_start = 1'b0;
        tick();
        r_we = 1'b1; wdata = 8'h55;
        ex("r_we_wins", F_R, 16'h0055); ex("r_we_idle", F_BUSY, 16'h0);
        tick();
        idle_inputs(); m1_start = 1'b1;
        ex("addr_3c55", F_ADDR, 16'h3C55);
        tick();
        m1_start = 1'b0;
        tick();
        ex("r_56", F_R, 16'h0056);
        tick();

        // Overrun: starts in T3 and on the T4 edge are both ignored
        m1_start = 1'b1;
        ex("ov_t3_ovr", F_OVR, 16'h0);
        tick();
        ex("ov_t4_ovr", F_OVR, 16'h1); ex("ov_t4_busy", F_BUSY, 16'h1);
        ex("ov_t4_mreq", F_MREQ, 16'h0);
        tick();
        ex("ov_end_ovr", F_OVR, 16'h1); ex("ov_end_busy", F_BUSY, 16'h0);
        ex("ov_end_r", F_R, 16'h0057);
        tick();
        m1_start = 1'b0;
        ex("ov_clr_ovr", F_OVR, 16'h0); ex("ov_clr_r", F_R, 16'h0057);
        ex("ov_clr_rfsh", F_RFSH, 16'h0);
        tick();

        // Reset during T4 beats increment and coinciding writes
        i_we = 1'b1; wdata = 8'h80;
        tick();
        idle_inputs(); r_we = 1'b1; wdata = 8'h22;
        tick();
        idle_inputs(); m1_start = 1'b1;
        ex("pre_rst_addr", F_ADDR, 16'h8022);
        tick();
        m1_start = 1'b0;
        ex("pre_rst_t4", F_RFSH, 16'h1);
        tick();
        reset = 1'b1; i_we = 1'b1; r_we = 1'b1; wdata = 8'h99;
        ex_reset("rst_t4");
        tick();
        reset = 1'b0; idle_inputs();
        ex("post_rst_r", F_R, 16'h0000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
